// File: rtl/uart_tx_if.sv
// Request/serializer bundle for the UART TX scheduler.
// The scheduler takes the slave side; requesters and serializer take the master side.
interface uart_tx_if;
    logic        req0;
    logic [31:0] word0;
    logic        req1;
    logic [31:0] word1;
    logic        ack0;
    logic        ack1;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        parity_sel;
    logic        tx_sel;
    logic        busy;
    logic        grant_id;
    logic        timeout_err;
    logic        err_clr;

    modport master (
        output req0, word0, req1, word1, tx_done, err_clr,
        input  ack0, ack1, tx_data, parity_sel, tx_sel, busy, grant_id, timeout_err
    );

    modport slave (
        input  req0, word0, req1, word1, tx_done, err_clr,
        output ack0, ack1, tx_data, parity_sel, tx_sel, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler handing UART_TX words from two requesters to one serializer,
// with a completion timeout and a post-frame guard gap.
//
// state     | meaning
// IDLE      | waiting for a request; grants and acks combinationally
// START     | one-cycle start strobe to the serializer
// WAIT_DONE | counting cycles until tx_done or timeout
// GUARD     | idle gap of GUARD_CYCLES before the next grant
module uart_tx_scheduler #(
    parameter int GUARD_CYCLES = 2,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int WAIT_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(DONE_TIMEOUT - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GUARD} state_t;

    state_t              state, state_nx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [GUARD_W-1:0]  guard_cnt;
    logic [7:0]          data_q;
    logic                par_q;
    logic                grant_q;
    logic                err_q;
    logic                pick0, pick1, grant_any, timeout_hit, frame_end;
    logic                unused_word_bits;

    assign unused_word_bits = ^{bus.word0[31:9], bus.word1[31:9]};

    always_comb begin
        // requester 1 wins a tie only when requester 0 owned the previous frame
        pick1       = bus.req1 & (~bus.req0 | ~grant_q);
        pick0       = bus.req0 & ~pick1;
        grant_any   = (state == IDLE) & (bus.req0 | bus.req1);
        frame_end   = (state == WAIT_DONE) & (bus.tx_done | (wait_cnt == WAIT_LAST));
        timeout_hit = (state == WAIT_DONE) & ~bus.tx_done & (wait_cnt == WAIT_LAST);
        state_nx    = state;
        case (state)
            IDLE:      if (grant_any) state_nx = START;
            START:     state_nx = WAIT_DONE;
            WAIT_DONE: if (frame_end) state_nx = (GUARD_CYCLES == 0) ? IDLE : GUARD;
            GUARD:     if (guard_cnt == GUARD_LAST) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            guard_cnt <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            grant_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            if (grant_any) begin
                data_q  <= pick1 ? bus.word1[7:0] : bus.word0[7:0];
                par_q   <= pick1 ? bus.word1[8]   : bus.word0[8];
                grant_q <= pick1;
            end
            wait_cnt  <= (state == WAIT_DONE && state_nx == WAIT_DONE) ? wait_cnt + 1'b1 : '0;
            guard_cnt <= (state == GUARD && state_nx == GUARD) ? guard_cnt + 1'b1 : '0;
            if (timeout_hit)      err_q <= 1'b1;
            else if (bus.err_clr) err_q <= 1'b0;
        end
    end

    // acks are gated by rst so a held request cannot glitch them during reset
    assign bus.ack0        = ~rst & grant_any & pick0;
    assign bus.ack1        = ~rst & grant_any & pick1;
    assign bus.tx_sel      = (state == START);
    assign bus.busy        = (state != IDLE);
    assign bus.tx_data     = data_q;
    assign bus.parity_sel  = par_q;
    assign bus.grant_id    = grant_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance with a short timeout and
// a second with no guard gap.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   w;

    always #5 clk = ~clk;

    uart_tx_if a_if ();
    uart_tx_if b_if ();

    uart_tx_scheduler #(.GUARD_CYCLES(2), .DONE_TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );

    uart_tx_scheduler #(.GUARD_CYCLES(0), .DONE_TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // waits for a grant on dut_a, checks it, then runs the frame to the first GUARD cycle
    task automatic frame_a(input logic exp_id, input logic [7:0] exp_data, input logic exp_par,
                           input int nwait, output int idle_wait);
        idle_wait = 0;
        while (!(a_if.ack0 | a_if.ack1) && idle_wait < 40) begin
            tick();
            settle();
            idle_wait++;
        end
        chk("ack_seen", {31'd0, a_if.ack0 | a_if.ack1}, 32'd1);
        chk("ack_id", {31'd0, a_if.ack1}, {31'd0, exp_id});
        chk("ack_onehot", {31'd0, a_if.ack0 & a_if.ack1}, 32'd0);
        tick();
        settle();
        chk("ack_single", {31'd0, a_if.ack0 | a_if.ack1}, 32'd0);
        chk("frame_tx_sel", {31'd0, a_if.tx_sel}, 32'd1);
        chk("frame_data", {24'd0, a_if.tx_data}, {24'd0, exp_data});
        chk("frame_par", {31'd0, a_if.parity_sel}, {31'd0, exp_par});
        chk("frame_grant", {31'd0, a_if.grant_id}, {31'd0, exp_id});
        for (int i = 1; i <= nwait; i++) begin
            tick();
            if (i == nwait) a_if.tx_done = 1'b1;
            settle();
        end
        tick();
        a_if.tx_done = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        a_if.req0 = 1'b1; a_if.word0 = 32'h0000_01A5;
        a_if.req1 = 1'b0; a_if.word1 = 32'h0;
        a_if.tx_done = 1'b0; a_if.err_clr = 1'b0;
        b_if.req0 = 1'b0; b_if.word0 = 32'h0;
        b_if.req1 = 1'b0; b_if.word1 = 32'h0;
        b_if.tx_done = 1'b0; b_if.err_clr = 1'b0;

        // reset values with a request already pending
        #12;
        chk("rst_busy", {31'd0, a_if.busy}, 32'd0);
        chk("rst_ack0", {31'd0, a_if.ack0}, 32'd0);
        chk("rst_tx_sel", {31'd0, a_if.tx_sel}, 32'd0);
        chk("rst_grant", {31'd0, a_if.grant_id}, 32'd1);
        chk("rst_data", {24'd0, a_if.tx_data}, 32'd0);
        chk("rst_par", {31'd0, a_if.parity_sel}, 32'd0);
        chk("rst_err", {31'd0, a_if.timeout_err}, 32'd0);

        // single request, tx_done after 10 cycles
        @(negedge clk) rst = 1'b0;
        #1;
        chk("s_ack0", {31'd0, a_if.ack0}, 32'd1);
        chk("s_idle_busy", {31'd0, a_if.busy}, 32'd0);
        tick();
        a_if.req0 = 1'b0;
        settle();
        chk("s_ack0_off", {31'd0, a_if.ack0}, 32'd0);
        chk("s_tx_sel", {31'd0, a_if.tx_sel}, 32'd1);
        chk("s_data", {24'd0, a_if.tx_data}, 32'hA5);
        chk("s_par", {31'd0, a_if.parity_sel}, 32'd1);
        chk("s_grant", {31'd0, a_if.grant_id}, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 10) a_if.tx_done = 1'b1;
            settle();
            if (i == 1) chk("s_tx_sel_once", {31'd0, a_if.tx_sel}, 32'd0);
            if (i == 10) chk("s_wait_busy", {31'd0, a_if.busy}, 32'd1);
        end
        tick();
        a_if.tx_done = 1'b0;
        settle();
        chk("s_guard1_busy", {31'd0, a_if.busy}, 32'd1);
        chk("s_data_stable", {24'd0, a_if.tx_data}, 32'hA5);
        tick(); settle();
        chk("s_guard2_busy", {31'd0, a_if.busy}, 32'd1);
        tick(); settle();
        chk("s_idle_after", {31'd0, a_if.busy}, 32'd0);

        // timeout with err_clr colliding on the expiring cycle
        a_if.word0 = 32'h0000_00C3;
        a_if.req0 = 1'b1;
        #1;
        chk("t_ack0", {31'd0, a_if.ack0}, 32'd1);
        tick();
        a_if.req0 = 1'b0;
        settle();
        chk("t_data", {24'd0, a_if.tx_data}, 32'hC3);
        chk("t_par", {31'd0, a_if.parity_sel}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 16) a_if.err_clr = 1'b1;
            settle();
            if (i == 16) begin
                chk("t_err_pre", {31'd0, a_if.timeout_err}, 32'd0);
                chk("t_busy_last", {31'd0, a_if.busy}, 32'd1);
            end
        end
        tick();
        a_if.err_clr = 1'b0;
        settle();
        chk("t_err_set_wins", {31'd0, a_if.timeout_err}, 32'd1);
        chk("t_guard_busy", {31'd0, a_if.busy}, 32'd1);
        tick(); settle();
        tick(); settle();
        chk("t_idle_busy", {31'd0, a_if.busy}, 32'd0);
        chk("t_err_sticky", {31'd0, a_if.timeout_err}, 32'd1);
        a_if.err_clr = 1'b1;
        tick();
        a_if.err_clr = 1'b0;
        settle();
        chk("t_err_clr", {31'd0, a_if.timeout_err}, 32'd0);

        // tx_done on the final timeout cycle is a normal completion
        a_if.word0 = 32'h0000_0100;
        a_if.req0 = 1'b1;
        #1;
        chk("b_ack0", {31'd0, a_if.ack0}, 32'd1);
        tick();
        a_if.req0 = 1'b0;
        settle();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 16) a_if.tx_done = 1'b1;
            settle();
        end
        tick();
        a_if.tx_done = 1'b0;
        settle();
        chk("bnd_err", {31'd0, a_if.timeout_err}, 32'd0);
        chk("bnd_guard_busy", {31'd0, a_if.busy}, 32'd1);
        tick(); settle();
        tick(); settle();
        chk("bnd_idle", {31'd0, a_if.busy}, 32'd0);

        // reset in WAIT_DONE, then contention restarts at requester 0
        a_if.word1 = 32'hFFFF_FE5C;
        a_if.req1 = 1'b1;
        #1;
        chk("r_ack1", {31'd0, a_if.ack1}, 32'd1);
        tick();
        a_if.req1 = 1'b0;
        settle();
        chk("r_grant1", {31'd0, a_if.grant_id}, 32'd1);
        chk("r_data", {24'd0, a_if.tx_data}, 32'h5C);
        tick(); settle();
        tick(); settle();
        chk("r_wait_busy", {31'd0, a_if.busy}, 32'd1);
        #1;
        rst = 1'b1;
        a_if.word0 = 32'h0000_0133;
        a_if.req0 = 1'b1;
        a_if.req1 = 1'b1;
        #1;
        chk("r_async_busy", {31'd0, a_if.busy}, 32'd0);
        chk("r_async_data", {24'd0, a_if.tx_data}, 32'd0);
        chk("r_async_grant", {31'd0, a_if.grant_id}, 32'd1);
        chk("r_async_acks", {30'd0, a_if.ack1, a_if.ack0}, 32'd0);
        tick(); settle();
        chk("r_hold_tx_sel", {31'd0, a_if.tx_sel}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        frame_a(1'b0, 8'h33, 1'b1, 5, w);
        chk("c_first_wait", w, 32'd0);
        frame_a(1'b1, 8'h5C, 1'b0, 3, w);
        chk("c_gap1", w, 32'd2);
        frame_a(1'b0, 8'h33, 1'b1, 7, w);
        chk("c_gap2", w, 32'd2);
        frame_a(1'b1, 8'h5C, 1'b0, 4, w);
        chk("c_gap3", w, 32'd2);
        a_if.req0 = 1'b0;
        a_if.req1 = 1'b0;

        // no guard gap: back-to-back requester 0
        b_if.word0 = 32'h0000_017E;
        b_if.req0 = 1'b1;
        #1;
        chk("g0_ack0", {31'd0, b_if.ack0}, 32'd1);
        tick(); settle();
        chk("g0_tx_sel", {31'd0, b_if.tx_sel}, 32'd1);
        chk("g0_data", {24'd0, b_if.tx_data}, 32'h7E);
        tick(); settle();
        tick(); settle();
        tick();
        b_if.tx_done = 1'b1;
        settle();
        chk("g0_no_ack_wait", {31'd0, b_if.ack0}, 32'd0);
        tick();
        b_if.tx_done = 1'b0;
        settle();
        chk("g0_ack_again", {31'd0, b_if.ack0}, 32'd1);
        chk("g0_idle", {31'd0, b_if.busy}, 32'd0);
        tick();
        b_if.req0 = 1'b0;
        settle();
        chk("g0_tx_sel2", {31'd0, b_if.tx_sel}, 32'd1);
        tick();
        b_if.tx_done = 1'b1;
        settle();
        tick();
        b_if.tx_done = 1'b0;
        settle();
        chk("g0_end_idle", {31'd0, b_if.busy}, 32'd0);
        chk("g0_err", {31'd0, b_if.timeout_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
